// File: rtl/data_sram_bridge.sv
// data_sram_bridge: memory end of the CPU data port, serving 32-bit accesses from a 16-bit async SRAM.
// Latency: 1 + (active half-word phases)*(WAIT_CYCLES+1) stall cycles, then one DONE cycle with data_o valid.
// Backpressure: stallreq_o holds the pipeline for the whole access; requests are only accepted in IDLE.
module data_sram_bridge #(
  parameter int SRAM_AW     = 20,
  parameter int WAIT_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ce_i,
  input  logic               we_i,
  input  logic [31:0]        addr_i,
  input  logic [3:0]         sel_i,
  input  logic [31:0]        data_i,
  output logic [31:0]        data_o,
  output logic               stallreq_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [15:0]        sram_dq_o,
  input  logic [15:0]        sram_dq_i,
  output logic               sram_dq_oe_o,
  output logic               sram_ce_n_o,
  output logic               sram_oe_n_o,
  output logic               sram_we_n_o,
  output logic [1:0]         sram_be_n_o
);

  localparam int CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, HI, LO, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      wait_cnt;
  logic               we_q;
  logic [SRAM_AW-2:0] waddr_q;
  logic [3:0]         sel_q;
  logic [31:0]        data_q;

  logic               req_we;
  logic [SRAM_AW-2:0] req_waddr;
  logic [3:0]         req_sel;
  logic [31:0]        req_data;
  logic               phase_last;
  logic               setup_lo;
  logic               phase_start;
  logic               phase_stop;
  logic               addr_unused;

  // Address bits outside the SRAM word range are deliberately dropped (the SRAM space wraps).
  assign addr_unused = &{1'b0, addr_i[31:SRAM_AW+1], addr_i[1:0]};

  // Request view: live CPU inputs while accepting in IDLE, the latched copy afterwards
  always_comb begin
    req_we    = we_q;
    req_waddr = waddr_q;
    req_sel   = sel_q;
    req_data  = data_q;
    if (state == IDLE) begin
      req_we    = we_i;
      req_waddr = addr_i[SRAM_AW:2];
      req_sel   = sel_i;
      req_data  = data_i;
    end
  end

  assign phase_last = (wait_cnt == LAST);
  // The phase being set up is LO unless an IDLE request has an upper half to serve first.
  assign setup_lo   = (state != IDLE) || (sel_i[3:2] == 2'b00);
  assign phase_start = ((state == IDLE) && ce_i && (sel_i != 4'b0000)) ||
                       ((state == HI) && phase_last && (sel_q[1:0] != 2'b00));
  assign phase_stop  = ((state == HI) || (state == LO)) && phase_last && !phase_start;

  // Stall is combinational on the request in IDLE so the requesting cycle itself is held.
  assign stallreq_o = (state == IDLE) ? (ce_i & rst) : ((state == HI) || (state == LO));

  // Sequencer: latch the request, walk the half-word phases, assemble read data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      sel_q    <= 4'b0000;
      data_q   <= 32'h0;
      data_o   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (ce_i) begin
            we_q     <= we_i;
            waddr_q  <= addr_i[SRAM_AW:2];
            sel_q    <= sel_i;
            data_q   <= data_i;
            data_o   <= 32'h0;
            wait_cnt <= '0;
            if (sel_i == 4'b0000) state <= DONE;
            else if (setup_lo)    state <= LO;
            else                  state <= HI;
          end
        end
        HI, LO: begin
          if (!we_q && phase_last) begin
            if (state == HI) data_o[31:16] <= sram_dq_i & {{8{sel_q[3]}}, {8{sel_q[2]}}};
            else             data_o[15:0]  <= sram_dq_i & {{8{sel_q[1]}}, {8{sel_q[0]}}};
          end
          if (!phase_last) begin
            wait_cnt <= wait_cnt + CW'(1);
          end else if (phase_start) begin
            state    <= LO;
            wait_cnt <= '0;
          end else begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered SRAM pins: driven for a phase on its entry edge, released when the access ends
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sram_addr_o  <= '0;
      sram_dq_o    <= 16'h0;
      sram_dq_oe_o <= 1'b0;
      sram_ce_n_o  <= 1'b1;
      sram_oe_n_o  <= 1'b1;
      sram_we_n_o  <= 1'b1;
      sram_be_n_o  <= 2'b11;
    end else if (phase_start) begin
      sram_addr_o  <= {req_waddr, setup_lo};
      sram_be_n_o  <= setup_lo ? ~req_sel[1:0] : ~req_sel[3:2];
      sram_dq_o    <= setup_lo ? req_data[15:0] : req_data[31:16];
      sram_ce_n_o  <= 1'b0;
      sram_oe_n_o  <= req_we;
      sram_we_n_o  <= ~req_we;
      sram_dq_oe_o <= req_we;
    end else if (phase_stop) begin
      sram_ce_n_o  <= 1'b1;
      sram_oe_n_o  <= 1'b1;
      sram_we_n_o  <= 1'b1;
      sram_be_n_o  <= 2'b11;
      sram_dq_oe_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_sram_bridge.sv
// tb_data_sram_bridge: randomized scoreboard bench with a byte-level memory reference model.
// Latency: expectations are queued at issue; monitors pop on SRAM activity and on each DONE.
// Backpressure: the driver holds each request until stallreq_o drops, bounded by a cycle budget.
module tb_data_sram_bridge;

  localparam int AW = 12;
  localparam int W  = 1;
  localparam int PH = W + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce_i, we_i;
  logic [31:0]   addr_i, data_i;
  logic [3:0]    sel_i;
  logic [31:0]   data_o;
  logic          stallreq_o;
  logic [AW-1:0] sram_addr_o;
  logic [15:0]   sram_dq_o, sram_dq_i;
  logic          sram_dq_oe_o, sram_ce_n_o, sram_oe_n_o, sram_we_n_o;
  logic [1:0]    sram_be_n_o;

  always #5 clk = ~clk;

  data_sram_bridge #(.SRAM_AW(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .we_i(we_i), .addr_i(addr_i), .sel_i(sel_i),
    .data_i(data_i), .data_o(data_o), .stallreq_o(stallreq_o), .sram_addr_o(sram_addr_o),
    .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i), .sram_dq_oe_o(sram_dq_oe_o),
    .sram_ce_n_o(sram_ce_n_o), .sram_oe_n_o(sram_oe_n_o), .sram_we_n_o(sram_we_n_o),
    .sram_be_n_o(sram_be_n_o)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    be_n;
    logic          oe_n;
    logic          we_n;
    logic          dq_oe;
    logic [15:0]   dq;
  } trace_t;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  stall;
  } resp_t;

  trace_t trace_q[$];
  resp_t  resp_q[$];
  int     n_pass  = 0;
  int     n_total = 0;
  bit     mon_en  = 1'b0;

  // Async SRAM device (half-word organised) and reference model (byte organised)
  logic [15:0] dev_mem [0:(1<<AW)-1];
  logic [7:0]  ref_mem [0:(1<<(AW+1))-1];

  always @(posedge clk) begin
    if (!sram_ce_n_o && !sram_we_n_o) begin
      if (!sram_be_n_o[1]) dev_mem[sram_addr_o][15:8] <= sram_dq_o[15:8];
      if (!sram_be_n_o[0]) dev_mem[sram_addr_o][7:0]  <= sram_dq_o[7:0];
    end
  end

  assign sram_dq_i = (!sram_ce_n_o && !sram_oe_n_o) ? dev_mem[sram_addr_o] : 16'hA5A5;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s", name);
  endtask

  // Expected SRAM traffic and CPU response, derived from byte lanes and phase counts
  task automatic expect_access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                               input logic [31:0] data);
    int     base;
    int     nph;
    logic [1:0] hs;
    resp_t  r;
    trace_t t;
    base   = int'(addr[AW:2]) * 4;
    nph    = 0;
    r.data = 32'h0;
    for (int h = 0; h < 2; h++) begin
      hs = (h == 0) ? sel[3:2] : sel[1:0];
      if (hs != 2'b00) begin
        nph++;
        for (int c = 0; c < PH; c++) begin
          t.addr  = AW'(base / 2 + h);
          t.be_n  = ~hs;
          t.oe_n  = we;
          t.we_n  = ~we;
          t.dq_oe = we;
          t.dq    = (h == 0) ? data[31:16] : data[15:0];
          trace_q.push_back(t);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      if (sel[3-k]) begin
        if (we) ref_mem[base+k] = data[31-8*k -: 8];
        else    r.data[31-8*k -: 8] = ref_mem[base+k];
      end
    end
    r.stall = 8'(1 + nph * PH);
    resp_q.push_back(r);
  endtask

  task automatic do_access(input logic we, input logic [31:0] addr, input logic [3:0] sel,
                           input logic [31:0] data, input bit drop);
    int cyc;
    bit fin;
    @(posedge clk);
    #1;
    expect_access(we, addr, sel, data);
    ce_i = 1'b1; we_i = we; addr_i = addr; sel_i = sel; data_i = data;
    cyc = 0;
    fin = 1'b0;
    while (!fin) begin
      @(negedge clk);
      if (!stallreq_o) begin
        fin = 1'b1;
      end else begin
        cyc++;
        if (cyc > 30) begin
          fail_now("access_timeout");
          fin = 1'b1;
        end else if (drop && cyc >= 2) begin
          #1 ce_i = 1'b0;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk);
    #1 ce_i = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  // Response monitor: a falling stall marks DONE; check assembled data and stall length
  int    run = 0;
  resp_t mon_r;
  always @(negedge clk) begin
    if (!mon_en) begin
      run = 0;
    end else if (stallreq_o) begin
      run++;
    end else if (run > 0) begin
      if (resp_q.size() == 0) begin
        fail_now("unexpected_response");
      end else begin
        mon_r = resp_q.pop_front();
        chk("data_o", data_o, mon_r.data);
        chk("stall_cycles", 32'(run), 32'(mon_r.stall));
      end
      run = 0;
    end
  end

  // SRAM-side monitor: every cycle with chip enable low must match the next expected phase cycle
  trace_t mon_t;
  always @(negedge clk) begin
    if (mon_en) begin
      if (!sram_ce_n_o) begin
        if (trace_q.size() == 0) begin
          fail_now("unexpected_sram_cycle");
        end else begin
          mon_t = trace_q.pop_front();
          chk("sram_addr", 32'(sram_addr_o), 32'(mon_t.addr));
          chk("sram_ctl", {27'h0, sram_be_n_o, sram_oe_n_o, sram_we_n_o, sram_dq_oe_o},
              {27'h0, mon_t.be_n, mon_t.oe_n, mon_t.we_n, mon_t.dq_oe});
          if (mon_t.dq_oe) chk("sram_dq", 32'(sram_dq_o), 32'(mon_t.dq));
        end
      end else begin
        chk("idle_strobes", {27'h0, sram_oe_n_o, sram_we_n_o, sram_be_n_o, sram_dq_oe_o},
            {27'h0, 5'b11110});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  logic [31:0] ra, rd;
  logic [3:0]  rs;
  logic        rw;
  bit          rdrop;
  int          cyc;

  initial begin
    for (int i = 0; i < (1 << AW); i++) dev_mem[i] = 16'h0;
    for (int i = 0; i < (1 << (AW + 1)); i++) ref_mem[i] = 8'h0;
    rst = 1'b0; ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h10; sel_i = 4'hF; data_i = 32'hFFFF_FFFF;

    // Reset held with a live request: nothing may move
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(stallreq_o), 32'h0);
    chk("rst_strobes", {28'h0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_dq_oe_o}, 32'hE);
    chk("rst_be_n", 32'(sram_be_n_o), 32'h3);
    chk("rst_data_o", data_o, 32'h0);
    chk("rst_sram_addr", 32'(sram_addr_o), 32'h0);
    chk("rst_sram_dq", 32'(sram_dq_o), 32'h0);
    #2 rst = 1'b1;
    ce_i = 1'b0;
    mon_en = 1'b1;

    // Directed accesses from the plan, including the no-op and address wrap
    do_access(1'b1, 32'h0000_0010, 4'hF, 32'h1122_3344, 1'b0);
    idle(2);
    do_access(1'b0, 32'h0000_0010, 4'hF, 32'h0, 1'b0);
    do_access(1'b0, 32'h0000_0010, 4'b0010, 32'h0, 1'b0);
    do_access(1'b1, 32'h0000_0010, 4'h0, 32'hDEAD_BEEF, 1'b0);
    do_access(1'b0, 32'h0000_0010, 4'h0, 32'h0, 1'b0);
    do_access(1'b0, 32'hFFFF_E013, 4'hF, 32'h0, 1'b1);
    idle(2);

    // Async reset in the LO phase of a write: upper half lands, lower half never does
    mon_en = 1'b0;
    @(posedge clk);
    #1 ce_i = 1'b1; we_i = 1'b1; addr_i = 32'h20; sel_i = 4'hF; data_i = 32'hCAFE_F00D;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(!sram_ce_n_o && sram_addr_o[0]) && cyc < 20);
    if (cyc >= 20) fail_now("lo_phase_timeout");
    #1 rst = 1'b0;
    #1;
    chk("abort_strobes", {28'h0, sram_ce_n_o, sram_we_n_o, sram_dq_oe_o, stallreq_o}, 32'hC);
    chk("abort_data_o", data_o, 32'h0);
    ce_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ref_mem[32] = 8'hCA;
    ref_mem[33] = 8'hFE;
    mon_en = 1'b1;
    do_access(1'b0, 32'h20, 4'hF, 32'h0, 1'b0);

    // Randomized back-to-back and gapped traffic over a small aliased window
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      ra[AW:2] = (AW-1)'($urandom_range(0, 7));
      rd = $urandom;
      rs = 4'($urandom_range(0, 15));
      rw = 1'($urandom_range(0, 1));
      rdrop = ($urandom_range(0, 3) == 0);
      do_access(rw, ra, rs, rd, rdrop);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(3);
    chk("resp_q_drained", 32'(resp_q.size()), 32'h0);
    chk("trace_q_drained", 32'(trace_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
